// File: rtl/weekday_table_gen_if.sv
// Write-side bundle between the weekday table generator and the weekday lookup BRAM.
// The generator drives the BRAM port and reports progress back to the requester.
interface weekday_table_gen_if #(
   parameter int ADDR_W = 12
);
   logic              start;
   logic              busy;
   logic              done;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [3:0]        wr_data;

   modport master (
      input  start,
      output busy, done, wr_en, wr_addr, wr_data
   );

   modport slave (
      output start,
      input  busy, done, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/weekday_table_gen.sv
// Rebuilds the weekday-of-the-1st lookup table, one (year, month) entry per clock,
// walking the calendar incrementally so no multiply, divide or modulo is needed.
module weekday_table_gen #(
   parameter int BASE_YEAR  = 2000,
   parameter int BASE_WDAY  = 6,
   parameter int YEAR_COUNT = 341,
   parameter int ADDR_W     = 12
) (
   input logic                    clk,
   input logic                    rst_n,
   weekday_table_gen_if.master    bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(YEAR_COUNT * 12 - 1);
   localparam logic [2:0]        WDAY_INIT = 3'(BASE_WDAY);
   localparam logic [1:0]        C4_INIT   = 2'(BASE_YEAR % 4);
   localparam logic [6:0]        C100_INIT = 7'(BASE_YEAR % 100);
   localparam logic [8:0]        C400_INIT = 9'(BASE_YEAR % 400);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic              r_wr_en, w_wr_en_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [2:0]        r_wday, w_wday_nxt;
   logic [3:0]        r_month, w_month_nxt;
   logic [1:0]        r_c4, w_c4_nxt;
   logic [6:0]        r_c100, w_c100_nxt;
   logic [8:0]        r_c400, w_c400_nxt;
   logic              w_leap;

   // Days in the month reduced mod 7: the weekday shift from this 1st to the next.
   function automatic logic [1:0] dim_mod7(input logic [3:0] month, input logic leap);
      logic [1:0] shift;
      case (month)
         4'd2:                    shift = leap ? 2'd1 : 2'd0;
         4'd4, 4'd6, 4'd9, 4'd11: shift = 2'd2;
         default:                 shift = 2'd3;
      endcase
      return shift;
   endfunction

   function automatic logic [2:0] wday_add(input logic [2:0] wday, input logic [1:0] inc);
      logic [3:0] sum;
      sum = {1'b0, wday} + {2'b00, inc};
      if (sum >= 4'd7) sum = sum - 4'd7;
      return sum[2:0];
   endfunction

   assign w_leap = ((r_c4 == 2'd0) && (r_c100 != 7'd0)) || (r_c400 == 9'd0);

   always_comb begin
      w_state_nxt = r_state;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_wr_en_nxt = r_wr_en;
      w_addr_nxt  = r_addr;
      w_wday_nxt  = r_wday;
      w_month_nxt = r_month;
      w_c4_nxt    = r_c4;
      w_c100_nxt  = r_c100;
      w_c400_nxt  = r_c400;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_RUN;
               w_busy_nxt  = 1'b1;
               w_wr_en_nxt = 1'b1;
               w_addr_nxt  = '0;
               w_wday_nxt  = WDAY_INIT;
               w_month_nxt = 4'd1;
               w_c4_nxt    = C4_INIT;
               w_c100_nxt  = C100_INIT;
               w_c400_nxt  = C400_INIT;
            end
         end
         S_RUN: begin
            if (r_addr == LAST_ADDR) begin
               w_state_nxt = S_DONE;
               w_busy_nxt  = 1'b0;
               w_wr_en_nxt = 1'b0;
               w_done_nxt  = 1'b1;
            end else begin
               w_addr_nxt = r_addr + ADDR_W'(1);
               w_wday_nxt = wday_add(r_wday, dim_mod7(r_month, w_leap));
               if (r_month == 4'd12) begin
                  // Year rollover: leap counters track the year of the next entry.
                  w_month_nxt = 4'd1;
                  w_c4_nxt    = (r_c4 == 2'd3)     ? 2'd0 : r_c4 + 2'd1;
                  w_c100_nxt  = (r_c100 == 7'd99)  ? 7'd0 : r_c100 + 7'd1;
                  w_c400_nxt  = (r_c400 == 9'd399) ? 9'd0 : r_c400 + 9'd1;
               end else begin
                  w_month_nxt = r_month + 4'd1;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_wr_en_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_wr_en <= 1'b0;
         r_addr  <= '0;
         r_wday  <= 3'd0;
         r_month <= 4'd1;
         r_c4    <= 2'd0;
         r_c100  <= 7'd0;
         r_c400  <= 9'd0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_wr_en <= w_wr_en_nxt;
         r_addr  <= w_addr_nxt;
         r_wday  <= w_wday_nxt;
         r_month <= w_month_nxt;
         r_c4    <= w_c4_nxt;
         r_c100  <= w_c100_nxt;
         r_c400  <= w_c400_nxt;
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.wr_en   = r_wr_en;
   assign bus.wr_addr = r_addr;
   assign bus.wr_data = {1'b0, r_wday};

endmodule

// File: tb/tb_weekday_table_gen.sv
// Bench for weekday_table_gen: Zeller-based calendar model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_weekday_table_gen;

   localparam int ADDR_W = 12;
   localparam int N_ENT  = 341 * 12;
   localparam int LAST   = N_ENT - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   weekday_table_gen_if #(.ADDR_W(ADDR_W)) bus ();

   weekday_table_gen #(
      .BASE_YEAR (2000),
      .BASE_WDAY (6),
      .YEAR_COUNT(341),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_wr     = 0;
   int   n_done   = 0;
   logic mon_en   = 1'b0;
   logic [3:0] mem [N_ENT];

   // Reference: weekday (0=Sun) of the 1st of month m in year y, Zeller's congruence.
   function automatic int zeller(input int y, input int m);
      int yy, mm, k, j, h;
      yy = y;
      mm = m;
      if (mm < 3) begin
         mm = mm + 12;
         yy = yy - 1;
      end
      k = yy % 100;
      j = yy / 100;
      h = (1 + (13 * (mm + 1)) / 5 + k + k / 4 + j / 4 + 5 * j) % 7;
      return (h + 6) % 7;
   endfunction

   function automatic int model_at(input int a);
      return zeller(2000 + a / 12, (a % 12) + 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycle model: mode 0=idle, 1=writing, 2=completion pulse.
   int m_mode  = 0;
   int m_wr_en = 0;
   int m_busy  = 0;
   int m_done  = 0;
   int m_addr  = 0;
   int m_data  = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         check("wr_en",   {31'd0, bus.wr_en}, m_wr_en);
         check("busy",    {31'd0, bus.busy},  m_busy);
         check("done",    {31'd0, bus.done},  m_done);
         check("wr_addr", {20'd0, bus.wr_addr}, m_addr);
         check("wr_data", {28'd0, bus.wr_data}, m_data);
      end
      if (bus.wr_en === 1'b1) begin
         n_wr++;
         if (int'(bus.wr_addr) < N_ENT) mem[bus.wr_addr] = bus.wr_data;
      end
      if (bus.done === 1'b1) n_done++;
      // Advance the model with the inputs the next rising edge will sample.
      if (!rst_n) begin
         m_mode = 0; m_wr_en = 0; m_busy = 0; m_done = 0; m_addr = 0; m_data = 0;
      end else begin
         case (m_mode)
            0: begin
               m_done = 0;
               if (bus.start === 1'b1) begin
                  m_mode = 1; m_wr_en = 1; m_busy = 1; m_addr = 0; m_data = model_at(0);
               end
            end
            1: begin
               if (m_addr == LAST) begin
                  m_mode = 2; m_wr_en = 0; m_busy = 0; m_done = 1;
               end else begin
                  m_addr = m_addr + 1;
                  m_data = model_at(m_addr);
               end
            end
            default: begin
               m_mode = 0; m_done = 0;
            end
         endcase
      end
   end

   task automatic wait_done(input string name, output int cycles, output int busy_cyc);
      cycles   = 0;
      busy_cyc = 0;
      while (bus.done !== 1'b1 && cycles < 5000) begin
         if (bus.busy === 1'b1) busy_cyc++;
         tick();
         cycles++;
      end
      check(name, {31'd0, bus.done}, 1);
   endtask

   task automatic wait_writes(input string name, input int target);
      int cyc;
      cyc = 0;
      while (n_wr < target && cyc < 2000) begin
         tick();
         cyc++;
      end
      check(name, (n_wr >= target) ? 1 : 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc, busy_cyc, mism;
      bus.start = 1'b0;
      rst_n     = 1'b0;
      repeat (3) tick();
      check("rst_wr_en",   {31'd0, bus.wr_en}, 0);
      check("rst_busy",    {31'd0, bus.busy},  0);
      check("rst_done",    {31'd0, bus.done},  0);
      check("rst_wr_addr", {20'd0, bus.wr_addr}, 0);
      check("rst_wr_data", {28'd0, bus.wr_data}, 0);
      mon_en = 1'b1;

      // Start coinciding with reset must be ignored.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("start_in_reset_wr_en", {31'd0, bus.wr_en}, 0);
      check("start_in_reset_busy",  {31'd0, bus.busy},  0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Full build.
      for (int i = 0; i < N_ENT; i++) mem[i] = 4'hF;
      n_wr = 0; n_done = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("first_wr_en",   {31'd0, bus.wr_en}, 1);
      check("first_wr_addr", {20'd0, bus.wr_addr}, 0);
      check("first_wr_data", {28'd0, bus.wr_data}, 6);
      wait_done("run1_done_seen", cyc, busy_cyc);
      check("run1_busy_cycles", busy_cyc, 4092);
      check("run1_writes", n_wr, 4092);
      check("run1_hold_addr", {20'd0, bus.wr_addr}, 4091);
      // Start while in the completion state is dropped.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("start_in_done_wr_en", {31'd0, bus.wr_en}, 0);
      check("start_in_done_done",  {31'd0, bus.done},  0);
      repeat (3) tick();
      check("run1_done_pulses", n_done, 1);
      check("run1_idle_wr_en", {31'd0, bus.wr_en}, 0);

      check("model_jan2000", model_at(0), 6);
      check("model_feb2000", model_at(1), 2);
      check("model_mar2100", model_at(1202), 1);
      check("mem_0",    {28'd0, mem[0]},    6);
      check("mem_1",    {28'd0, mem[1]},    2);
      check("mem_2",    {28'd0, mem[2]},    3);
      check("mem_289",  {28'd0, mem[289]},  4);
      check("mem_290",  {28'd0, mem[290]},  5);
      check("mem_1200", {28'd0, mem[1200]}, 5);
      check("mem_1202", {28'd0, mem[1202]}, 1);
      check("mem_4080", {28'd0, mem[4080]}, zeller(2340, 1));
      mism = 0;
      for (int i = 0; i < N_ENT; i++) if (mem[i] !== 4'(model_at(i))) mism++;
      check("full_table_mismatches", mism, 0);

      // Start pulse mid-build: no restart, no extra writes.
      n_wr = 0; n_done = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_writes("run2_reach_100", 100);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("run2_no_restart_addr_nz", (bus.wr_addr != '0) ? 1 : 0, 1);
      wait_done("run2_done_seen", cyc, busy_cyc);
      repeat (5) tick();
      check("run2_writes", n_wr, 4092);
      check("run2_done_pulses", n_done, 1);

      // Reset mid-build, then rebuild.
      n_wr = 0; n_done = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_writes("run3_reach_500", 500);
      rst_n = 1'b0;
      tick();
      check("midrst_wr_en", {31'd0, bus.wr_en}, 0);
      check("midrst_busy",  {31'd0, bus.busy},  0);
      rst_n = 1'b1;
      repeat (5) tick();
      check("midrst_writes", n_wr, 501);
      check("midrst_no_done", n_done, 0);
      check("midrst_stays_idle", {31'd0, bus.wr_en}, 0);
      n_wr = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("rebuild_wr_addr", {20'd0, bus.wr_addr}, 0);
      check("rebuild_wr_data", {28'd0, bus.wr_data}, 6);
      wait_done("run4_done_seen", cyc, busy_cyc);
      repeat (2) tick();
      check("run4_writes", n_wr, 4092);
      check("run4_done_pulses", n_done, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
